// File: rtl/reg_file_pkg.sv
// Shared constants and types for the reg_file register bank.
package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int REG_COUNT  = 2 ** ADDR_W_DEF;

   typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: register-0 masking plus optional write-through
// bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_raw,
`ifdef REG_FILE_BYPASS_EN
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] reg_w,
   input  logic [DATA_W-1:0] bus_w,
`endif
   output logic [DATA_W-1:0] rd_data
);

   always_comb begin
      rd_data = rd_raw;
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && we && (reg_w != '0) && (rd_addr == reg_w))
         rd_data = bus_w;
`endif
      // Register 0 is hard-wired to zero regardless of storage or bypass.
      if (rd_addr == '0)
         rd_data = '0;
   end

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with asynchronous active-low clear.
// Optional write-through bypass on both read ports: define REG_FILE_BYPASS_EN.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] reg_w,
   input  logic [DATA_W-1:0] bus_w,
   input  logic [ADDR_W-1:0] reg_a,
   input  logic [ADDR_W-1:0] reg_b,
   output logic [DATA_W-1:0] bus_a,
   output logic [DATA_W-1:0] bus_b
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];

   // Writes to address 0 are dropped, so regs[0] stays at its reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (we && (reg_w != '0)) begin
         regs[reg_w] <= bus_w;
      end
   end

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_a (
      .rd_addr (reg_a),
      .rd_raw  (regs[reg_a]),
`ifdef REG_FILE_BYPASS_EN
      .rst_n   (rst_n),
      .we      (we),
      .reg_w   (reg_w),
      .bus_w   (bus_w),
`endif
      .rd_data (bus_a)
   );

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd_b (
      .rd_addr (reg_b),
      .rd_raw  (regs[reg_b]),
`ifdef REG_FILE_BYPASS_EN
      .rst_n   (rst_n),
      .we      (we),
      .reg_w   (reg_w),
      .bus_w   (bus_w),
`endif
      .rd_data (bus_b)
   );

endmodule

// File: tb/tb_reg_file.sv
// Directed and random checks of reg_file against a behavioural register model,
// with expected read values queued on drive and popped on sample.
module tb_reg_file;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          we;
   logic [AW-1:0] reg_w;
   logic [DW-1:0] bus_w;
   logic [AW-1:0] reg_a;
   logic [AW-1:0] reg_b;
   logic [DW-1:0] bus_a;
   logic [DW-1:0] bus_b;

   reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .reg_w (reg_w),
      .bus_w (bus_w),
      .reg_a (reg_a),
      .reg_b (reg_b),
      .bus_a (bus_a),
      .bus_b (bus_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] model [NR];
   int            n_pass  = 0;
   int            n_total = 0;

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] addr);
      if (addr == '0) return '0;
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && we && (reg_w != '0) && (addr == reg_w)) return bus_w;
`endif
      return model[addr];
   endfunction

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag = tag;
      e.a   = ref_read(reg_a);
      e.b   = ref_read(reg_b);
      sb.push_back(e);
   endtask

   task automatic check_one(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Sample after settling; always away from the rising edge.
   task automatic pop_check();
      exp_t e;
      #1;
      if (sb.size() == 0) begin
         n_total++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      check_one({e.tag, "_a"}, bus_a, e.a);
      check_one({e.tag, "_b"}, bus_b, e.b);
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
      reg_a = a;
      reg_b = b;
      push_exp(tag);
      pop_check();
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic clock_model();
      @(posedge clk);
      if (rst_n && we && (reg_w != '0)) model[reg_w] = bus_w;
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      we    = 1'b1;
      reg_w = addr;
      bus_w = data;
      clock_model();
      we    = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) model[i] = '0;
      rst_n = 1'b0;
      we    = 1'b0;
      reg_w = '0;
      bus_w = '0;
      reg_a = '0;
      reg_b = '0;
      #2;
      read_check("reset_r0_r1", 5'd0, 5'd1);
      read_check("reset_r31_r17", 5'd31, 5'd17);
      @(negedge clk);
      rst_n = 1'b1;

      wr(5'd5, 32'h1234_5678);
      read_check("write_read_r5", 5'd5, 5'd5);

      wr(5'd0, 32'hFFFF_FFFF);
      read_check("zero_reg", 5'd0, 5'd5);

      wr(5'd3, 32'hA5A5_A5A5);
      we    = 1'b0;
      reg_w = 5'd3;
      bus_w = 32'h0000_0001;
      clock_model();
      read_check("write_disable_r3", 5'd5, 5'd3);

      wr(5'd31, 32'h8000_0001);
      read_check("top_reg_r31", 5'd31, 5'd3);

      // Same-cycle read and write of register 9.
      wr(5'd9, 32'h0000_0011);
      we    = 1'b1;
      reg_w = 5'd9;
      bus_w = 32'h0000_0022;
      reg_a = 5'd9;
      reg_b = 5'd5;
`ifdef REG_FILE_BYPASS_EN
      #1 check_one("same_cycle_before", bus_a, 32'h0000_0022);
`else
      #1 check_one("same_cycle_before", bus_a, 32'h0000_0011);
`endif
      check_one("same_cycle_other_port", bus_b, 32'h1234_5678);
      @(posedge clk);
      model[9] = 32'h0000_0022;
      @(negedge clk);
      we = 1'b0;
      read_check("same_cycle_after", 5'd9, 5'd9);

      // Asynchronous reset mid-run, then a write attempted while held.
      wr(5'd7, 32'hDEAD_BEEF);
      read_check("pre_reset_r7", 5'd7, 5'd9);
      #3;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = '0;
      #1 check_one("async_reset_r7_a", bus_a, 32'h0);
      check_one("async_reset_r9_b", bus_b, 32'h0);
      @(negedge clk);
      wr(5'd7, 32'h5555_5555);
      rst_n = 1'b1;
      read_check("write_during_reset", 5'd7, 5'd3);
      wr(5'd7, 32'h0BAD_F00D);
      read_check("first_write_after_reset", 5'd7, 5'd0);

      // Random soak against the model; expected values queued before each edge.
      for (int c = 0; c < 250; c++) begin
         we    = (c % 2 == 0) ? 1'b1 : 1'(($urandom & 32'h3) == 0);
         reg_w = AW'($urandom_range(0, NR - 1));
         bus_w = $urandom;
         reg_a = (c % 7 == 0) ? reg_w : AW'($urandom_range(0, NR - 1));
         reg_b = (c % 5 == 0) ? reg_a : AW'($urandom_range(0, NR - 1));
         push_exp("soak");
         pop_check();
         clock_model();
      end
      we = 1'b0;
      read_check("soak_end", 5'd0, 5'd31);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
